// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter: round-robin sharing of one add/sub datapath between two valid/ready requesters
module addsub_rr_arbiter #(
  parameter int WIDTH       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk_main,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_A,
  input  logic [2*WIDTH-1:0] req_B,
  input  logic [1:0]         req_sub,
  output logic [WIDTH-1:0]   dp_A,
  output logic [WIDTH-1:0]   dp_B,
  output logic               dp_Sub,
  input  logic [WIDTH-1:0]   dp_Sum,
  input  logic               dp_Cout,
  input  logic               dp_Sign,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_sum,
  output logic               rsp_cout,
  output logic               rsp_sign,
  output logic               grant_id,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t             r_state, w_next;
  logic               r_last, r_gid, r_sub, r_cout, r_sign;
  logic [3:0]         r_cnt;
  logic [WIDTH-1:0]   r_a, r_b, r_sum;
  logic               w_g, w_accept;
  // both requesting: alternate away from the last served port
  assign w_g      = (req_valid == 2'b11) ? ~r_last : req_valid[1];
  assign w_accept = (r_state == IDLE) && (|req_valid);
  always_ff @(posedge clk_main or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = (r_state == IDLE) ? (w_accept ? EXEC : IDLE) :
             (r_state == EXEC) ? ((r_cnt == 4'd0) ? RESP : EXEC) :
             (rsp_ready[r_gid] ? IDLE : RESP);
  end
  always_comb begin
    req_ready = (w_accept && reset) ? (w_g ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = (r_state == RESP) ? (r_gid ? 2'b10 : 2'b01) : 2'b00;
    busy      = (r_state != IDLE);
  end
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      r_last <= 1'b1;
      r_gid  <= 1'b0;
      r_cnt  <= 4'd0;
      r_a    <= '0;
      r_b    <= '0;
      r_sub  <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_sign <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= w_g ? req_A[2*WIDTH-1:WIDTH] : req_A[WIDTH-1:0];
        r_b   <= w_g ? req_B[2*WIDTH-1:WIDTH] : req_B[WIDTH-1:0];
        r_sub <= w_g ? req_sub[1] : req_sub[0];
        r_gid <= w_g;
        r_cnt <= 4'(EXEC_CYCLES - 1);
      end
      if (r_state == EXEC) begin
        if (r_cnt == 4'd0) begin
          r_sum  <= dp_Sum;
          r_cout <= dp_Cout;
          r_sign <= dp_Sign;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
      if (r_state == RESP && rsp_ready[r_gid]) r_last <= r_gid;
    end
  end
  assign dp_A     = r_a;
  assign dp_B     = r_b;
  assign dp_Sub   = r_sub;
  assign rsp_sum  = r_sum;
  assign rsp_cout = r_cout;
  assign rsp_sign = r_sign;
  assign grant_id = r_gid;
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// tb_addsub_rr_arbiter: two arbiter instances (1 and 3 exec cycles) checked against a transaction-level model
module tb_addsub_rr_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req_valid = '0;
  logic [7:0] req_A = '0;
  logic [7:0] req_B = '0;
  logic [1:0] req_sub = '0;
  logic [1:0] rsp_ready = '0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // add: {cout,sum} is the 5-bit sum; sub: cout and sign both flag a negative difference
  function automatic logic [5:0] ref_calc(input logic [3:0] a, input logic [3:0] b, input logic s);
    int r;
    logic [3:0] sum;
    r   = s ? int'(a) - int'(b) : int'(a) + int'(b);
    sum = r[3:0];
    return {s ? (r < 0) : (r > 15), s && (r < 0), sum};
  endfunction

  genvar k;
  generate
    for (k = 0; k < 2; k++) begin : g_dut
      localparam int EC = (k == 0) ? 1 : 3;
      logic [1:0] req_ready, rsp_valid;
      logic [3:0] dp_a, dp_b, dp_sum, rsp_sum;
      logic       dp_sub, dp_cout, dp_sign, rsp_cout, rsp_sign, grant_id, busy;
      logic [4:0] wide_add;
      assign wide_add = {1'b0, dp_a} + {1'b0, dp_b};
      assign dp_sum   = dp_sub ? dp_a - dp_b : wide_add[3:0];
      assign dp_cout  = dp_sub ? (dp_a < dp_b) : wide_add[4];
      assign dp_sign  = dp_sub & (dp_a < dp_b);
      addsub_rr_arbiter #(.WIDTH(4), .EXEC_CYCLES(EC)) u_dut (
        .clk_main(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_sub(req_sub),
        .dp_A(dp_a), .dp_B(dp_b), .dp_Sub(dp_sub), .dp_Sum(dp_sum), .dp_Cout(dp_cout), .dp_Sign(dp_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_sign(rsp_sign), .grant_id(grant_id), .busy(busy)
      );
      int         m_st, cyc, acc;
      logic       m_last, m_g, g, e_sub;
      logic [3:0] e_a, e_b;
      logic [5:0] pend, cap;
      always @(negedge clk) begin
        if (!reset) begin
          m_st = 0; m_last = 1'b1; m_g = 1'b0; e_a = '0; e_b = '0; e_sub = 1'b0; cap = '0; cyc = 0;
          chk($sformatf("dut%0d reset_outputs", k),
              32'({req_ready, rsp_valid, dp_a, dp_b, dp_sub, rsp_sum, rsp_cout, rsp_sign, grant_id, busy}), 32'd0);
        end else begin
          cyc++;
          g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
          chk($sformatf("dut%0d req_ready", k), 32'(req_ready),
              32'((m_st == 0 && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00));
          chk($sformatf("dut%0d rsp_valid", k), 32'(rsp_valid),
              32'((m_st == 2) ? (m_g ? 2'b10 : 2'b01) : 2'b00));
          chk($sformatf("dut%0d busy", k), 32'(busy), 32'(m_st != 0));
          chk($sformatf("dut%0d grant_id", k), 32'(grant_id), 32'(m_g));
          chk($sformatf("dut%0d dp_ops", k), 32'({dp_a, dp_b, dp_sub}), 32'({e_a, e_b, e_sub}));
          chk($sformatf("dut%0d rsp_data", k), 32'({rsp_cout, rsp_sign, rsp_sum}), 32'(cap));
          if (m_st == 0 && req_valid != 2'b00) begin
            m_st = 1; acc = cyc; m_g = g;
            e_a   = g ? req_A[7:4] : req_A[3:0];
            e_b   = g ? req_B[7:4] : req_B[3:0];
            e_sub = g ? req_sub[1] : req_sub[0];
            pend  = ref_calc(e_a, e_b, e_sub);
          end else if (m_st == 1) begin
            if (cyc == acc + EC) begin m_st = 2; cap = pend; end
          end else if (m_st == 2 && rsp_ready[m_g]) begin
            m_st = 0; m_last = m_g;
          end
        end
      end
    end
  endgenerate

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(3);
    reset = 1'b1;
    step(2);
    // T1: port0 5+3
    req_valid = 2'b01; req_A = 8'h05; req_B = 8'h03; req_sub = 2'b00; rsp_ready = 2'b11;
    step(1);
    req_valid = 2'b00;
    step(7);
    // T2: port1 7+9 with response held off
    req_valid = 2'b10; req_A = 8'h70; req_B = 8'h90; rsp_ready = 2'b00;
    step(1);
    req_valid = 2'b00;
    step(12);
    chk("t2 rsp_valid", 32'(g_dut[0].rsp_valid), 32'(2'b10));
    chk("t2 rsp_sum_cout", 32'({g_dut[0].rsp_cout, g_dut[0].rsp_sum}), 32'(5'h10));
    chk("t2 ec3 rsp_valid", 32'(g_dut[1].rsp_valid), 32'(2'b10));
    rsp_ready = 2'b11;
    step(2);
    // T3: both ports continuously valid
    req_valid = 2'b11;
    for (int i = 0; i < 30; i++) begin
      req_A = 8'($urandom); req_B = 8'($urandom); req_sub = 2'($urandom);
      step(1);
    end
    // T4: asynchronous reset mid-operation
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t4 async_zero dut0", 32'({g_dut[0].rsp_valid, g_dut[0].dp_a, g_dut[0].dp_b, g_dut[0].rsp_sum,
        g_dut[0].rsp_cout, g_dut[0].grant_id, g_dut[0].busy, g_dut[0].req_ready}), 32'd0);
    chk("t4 async_zero dut1", 32'({g_dut[1].rsp_valid, g_dut[1].dp_a, g_dut[1].dp_b, g_dut[1].rsp_sum,
        g_dut[1].rsp_cout, g_dut[1].grant_id, g_dut[1].busy, g_dut[1].req_ready}), 32'd0);
    step(2);
    reset = 1'b1;
    #3;
    chk("t4 first_grant", 32'(g_dut[0].req_ready), 32'(2'b01));
    step(1);
    req_valid = 2'b00;
    step(8);
    // T5: port0 6-2
    req_valid = 2'b01; req_A = 8'h06; req_B = 8'h02; req_sub = 2'b01;
    step(1);
    req_valid = 2'b00;
    step(8);
    // T6: port1 appears and vanishes while port0 is being served
    req_valid = 2'b01; req_A = 8'h4c; req_B = 8'h1a; req_sub = 2'b00;
    step(1);
    req_valid = 2'b10;
    step(1);
    req_valid = 2'b00;
    step(8);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom); req_A = 8'($urandom); req_B = 8'($urandom);
      req_sub = 2'($urandom); rsp_ready = 2'($urandom);
      step(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
